// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types for the data-memory arbiter.
// FSM states, port index type, port count and small helpers.
package dmem_arb_pkg;

   localparam int NPORTS = 2;

   typedef logic port_t;

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_e;

   function automatic port_t other_port(input port_t p);
      return ~p;
   endfunction

   function automatic arb_state_e lock_state(input port_t p);
      return p ? LOCK1 : LOCK0;
   endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: 2-way round-robin grant selection.
// Pure combinational; the caller owns the pointer and lock state.
module dmem_rr_pick
   import dmem_arb_pkg::*;
(
   input  logic [NPORTS-1:0] valid_i,
   input  port_t             rr_i,
   input  logic              force_en_i,
   input  port_t             force_port_i,
   output logic [NPORTS-1:0] gnt_o
);

   // One-hot grant: forced port only, else favoured port on a tie.
   always_comb begin
      gnt_o = '0;
      unique case (1'b1)
         force_en_i: begin
            gnt_o[force_port_i] = valid_i[force_port_i];
         end
         (!force_en_i && (&valid_i)): begin
            gnt_o[rr_i] = 1'b1;
         end
         default: begin
            gnt_o = valid_i;
         end
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data SRAM between the LSU and the loader.
// Round-robin with a bounded lock; 1-cycle response routed to owner.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int MEM_DEPTH      = 4096,
   parameter int MEM_ADDR_WIDTH = 12,
   parameter int MAX_LOCK       = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [NPORTS-1:0]       i_req_valid,
   output logic [NPORTS-1:0]       o_req_ready,
   input  logic [NPORTS-1:0][31:0] i_req_addr,
   input  logic [NPORTS-1:0][31:0] i_req_wdata,
   input  logic [NPORTS-1:0][3:0]  i_req_size,
   input  logic [NPORTS-1:0]       i_req_write,
   input  logic [NPORTS-1:0]       i_req_lock,
   output logic [NPORTS-1:0]       o_rsp_valid,
   output logic [NPORTS-1:0][31:0] o_rsp_rdata,
   output logic [NPORTS-1:0]       o_rsp_err,
   output logic [31:0]             o_mem_addr,
   output logic [31:0]             o_mem_wr_data,
   output logic [3:0]              o_mem_size,
   output logic                    o_mem_write,
   output logic                    o_mem_read,
   input  logic [31:0]             i_mem_rd_data
);

   localparam int AW = MEM_ADDR_WIDTH;
   localparam int CW = $clog2(MAX_LOCK + 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);
   localparam logic [AW:0]   DEPTH_W = (AW + 1)'(MEM_DEPTH);

   arb_state_e    state_q, state_d;
   port_t         rr_q, rr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;

   logic          rsp_vld_q, rsp_vld_d;
   port_t         rsp_own_q, rsp_own_d;
   logic          rsp_rd_q, rsp_rd_d;
   logic          rsp_err_q, rsp_err_d;

   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    size_q, size_d;

   logic          force_en;
   port_t         force_port;
   logic [1:0]    gnt;
   logic          accept;
   port_t         gport;

   logic [31:0]   sel_addr;
   logic [31:0]   sel_wdata;
   logic [3:0]    sel_size;
   logic          sel_write;
   logic          sel_lock;
   logic          in_range;

   assign force_en   = (state_q != ARB);
   assign force_port = (state_q == LOCK1);

   dmem_rr_pick u_pick (
      .valid_i      (i_req_valid),
      .rr_i         (rr_q),
      .force_en_i   (force_en),
      .force_port_i (force_port),
      .gnt_o        (gnt)
   );

   assign o_req_ready = gnt;
   assign accept      = |gnt;
   assign gport       = gnt[1];

   assign sel_addr  = i_req_addr[gport];
   assign sel_wdata = i_req_wdata[gport];
   assign sel_size  = i_req_size[gport];
   assign sel_write = i_req_write[gport];
   assign sel_lock  = i_req_lock[gport];

   // Byte address below 4*MEM_DEPTH: upper bits clear, word index in range.
   assign in_range = (sel_addr[31:AW+2] == '0) &&
                     ({1'b0, sel_addr[AW+1:2]} < DEPTH_W);

   assign cnt_inc = cnt_q + CNT_ONE;

   // Arbitration FSM: pointer update, lock entry, lock exit conditions.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ARB: begin
            if (accept) begin
               rr_d = other_port(gport);
               if (sel_lock) begin
                  state_d = lock_state(gport);
                  cnt_d   = CNT_ONE;
               end
            end
         end
         LOCK0, LOCK1: begin
            if (!i_req_valid[force_port]) begin
               state_d = ARB;
            end else begin
               cnt_d = cnt_inc;
               if (!sel_lock) begin
                  state_d = ARB;
               end else if (cnt_inc == CNT_MAX) begin
                  state_d = ARB;
                  rr_d    = other_port(force_port);
               end
            end
         end
         default: begin
            state_d = ARB;
         end
      endcase
   end

   // Capture response tag and hold the last SRAM request fields.
   always_comb begin
      rsp_vld_d = accept;
      rsp_own_d = rsp_own_q;
      rsp_rd_d  = rsp_rd_q;
      rsp_err_d = rsp_err_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      size_d    = size_q;
      if (accept) begin
         rsp_own_d = gport;
         rsp_rd_d  = !sel_write;
         rsp_err_d = !in_range;
         addr_d    = sel_addr;
         wdata_d   = sel_wdata;
         size_d    = sel_size;
      end
   end

   // FSM, round-robin pointer and lock counter registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ARB;
         rr_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Response tag and held request-field registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rsp_vld_q <= 1'b0;
         rsp_own_q <= 1'b0;
         rsp_rd_q  <= 1'b0;
         rsp_err_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         size_q    <= '0;
      end else begin
         rsp_vld_q <= rsp_vld_d;
         rsp_own_q <= rsp_own_d;
         rsp_rd_q  <= rsp_rd_d;
         rsp_err_q <= rsp_err_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         size_q    <= size_d;
      end
   end

   assign o_mem_addr    = accept ? sel_addr : addr_q;
   assign o_mem_wr_data = accept ? sel_wdata : wdata_q;
   assign o_mem_size    = accept ? sel_size : size_q;
   assign o_mem_write   = accept & sel_write & in_range;
   assign o_mem_read    = accept & ~sel_write & in_range;

   // Route the registered response to its owner; others stay at zero.
   always_comb begin
      o_rsp_valid = '0;
      o_rsp_rdata = '0;
      o_rsp_err   = '0;
      if (rsp_vld_q) begin
         o_rsp_valid[rsp_own_q] = 1'b1;
         o_rsp_err[rsp_own_q]   = rsp_err_q;
         if (rsp_rd_q && !rsp_err_q) begin
            o_rsp_rdata[rsp_own_q] = i_mem_rd_data;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for the data-memory arbiter.
// Driver+model queue expectations; a monitor pops and compares.
module tb_dmem_arbiter;

   localparam int DEPTH = 4096;
   localparam int MAXL  = 16;
   localparam logic [31:0] LIMIT = 32'h4000;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  size;
      logic        write;
      logic        lock;
      int          gap;
   } req_t;

   typedef struct {
      int          cyc;
      logic [1:0]  rdy;
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  size;
   } cyc_exp_t;

   typedef struct {
      int          cyc;
      logic [31:0] rdata;
      logic        err;
   } rsp_exp_t;

   logic             clk;
   logic             rst_n;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0][31:0] req_addr;
   logic [1:0][31:0] req_wdata;
   logic [1:0][3:0]  req_size;
   logic [1:0]       req_write;
   logic [1:0]       req_lock;
   logic [1:0]       rsp_valid;
   logic [1:0][31:0] rsp_rdata;
   logic [1:0]       rsp_err;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wr_data;
   logic [3:0]       mem_size;
   logic             mem_write;
   logic             mem_read;
   logic [31:0]      mem_rdata;

   dmem_arbiter #(
      .MEM_DEPTH      (DEPTH),
      .MEM_ADDR_WIDTH (12),
      .MAX_LOCK       (MAXL)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_req_valid   (req_valid),
      .o_req_ready   (req_ready),
      .i_req_addr    (req_addr),
      .i_req_wdata   (req_wdata),
      .i_req_size    (req_size),
      .i_req_write   (req_write),
      .i_req_lock    (req_lock),
      .o_rsp_valid   (rsp_valid),
      .o_rsp_rdata   (rsp_rdata),
      .o_rsp_err     (rsp_err),
      .o_mem_addr    (mem_addr),
      .o_mem_wr_data (mem_wr_data),
      .o_mem_size    (mem_size),
      .o_mem_write   (mem_write),
      .o_mem_read    (mem_read),
      .i_mem_rd_data (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'hDEADBEEF;
      return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   // SRAM stand-in: request seen mid-cycle, applied at the edge.
   logic [31:0] sram [DEPTH];
   logic        loaded;
   logic        cap_we, cap_re;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_size;

   always @(negedge clk) begin
      cap_we    <= mem_write;
      cap_re    <= mem_read;
      cap_addr  <= mem_addr;
      cap_wdata <= mem_wr_data;
      cap_size  <= mem_size;
   end

   always @(posedge clk) begin
      if (loaded !== 1'b1) begin
         for (int i = 0; i < DEPTH; i++) sram[i] <= init_word(i);
         mem_rdata <= '0;
         loaded    <= 1'b1;
      end else begin
         if (cap_we)
            for (int b = 0; b < 4; b++)
               if (cap_size[b])
                  sram[cap_addr[13:2]][b*8 +: 8] <= cap_wdata[b*8 +: 8];
         if (cap_re) mem_rdata <= sram[cap_addr[13:2]];
      end
   end

   cyc_exp_t exp_q[$];
   rsp_exp_t rsp_q[2][$];
   int vectors, miscompares;
   int to_cnt, to_seen;

   // Monitor: every comparison against queued expectations lives here.
   initial begin : monitor
      cyc_exp_t    e;
      rsp_exp_t    r;
      logic        xv, xe;
      logic [31:0] xr;
      forever begin
         @(negedge clk);
         if (to_cnt != to_seen) begin
            to_seen = to_cnt;
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got work still pending, want idle");
         end
         if (!rst_n) begin
            vectors++;
            if (rsp_valid !== 2'b00 || rsp_rdata !== '0 ||
                rsp_err !== 2'b00 || mem_write !== 1'b0 ||
                mem_read !== 1'b0 || mem_addr !== '0 ||
                mem_wr_data !== '0 || mem_size !== '0) begin
               miscompares++;
               $display("FAIL reset_state cyc=%0d: got rv=%b re=%b we=%b rd=%b a=%h, want all 0",
                        cyc, rsp_valid, rsp_err, mem_write, mem_read, mem_addr);
            end
         end else begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
               e = exp_q.pop_front();
               vectors++;
               if (req_ready !== e.rdy) begin
                  miscompares++;
                  $display("FAIL ready cyc=%0d: got %b want %b", cyc, req_ready, e.rdy);
               end
               vectors++;
               if (mem_write !== e.we || mem_read !== e.re ||
                   mem_addr !== e.addr || mem_wr_data !== e.wdata ||
                   mem_size !== e.size) begin
                  miscompares++;
                  $display("FAIL mem_if cyc=%0d: got we=%b re=%b a=%h d=%h s=%h want we=%b re=%b a=%h d=%h s=%h",
                           cyc, mem_write, mem_read, mem_addr, mem_wr_data, mem_size,
                           e.we, e.re, e.addr, e.wdata, e.size);
               end
            end
            for (int p = 0; p < 2; p++) begin
               xv = 1'b0;
               xr = '0;
               xe = 1'b0;
               if (rsp_q[p].size() > 0 && rsp_q[p][0].cyc == cyc) begin
                  r  = rsp_q[p].pop_front();
                  xv = 1'b1;
                  xr = r.rdata;
                  xe = r.err;
               end
               vectors++;
               if (rsp_valid[p] !== xv || rsp_rdata[p] !== xr ||
                   rsp_err[p] !== xe) begin
                  miscompares++;
                  $display("FAIL rsp%0d cyc=%0d: got v=%b d=%h e=%b want v=%b d=%h e=%b",
                           p, cyc, rsp_valid[p], rsp_rdata[p], rsp_err[p], xv, xr, xe);
               end
            end
         end
      end
   end

   // Reference model state: who may be granted and what memory holds.
   logic [31:0] ref_mem [DEPTH];
   int          rr, lk, lk_n;
   logic [31:0] last_addr, last_wdata;
   logic [3:0]  last_size;

   req_t        stim_q[2][$];
   req_t        cur[2];
   logic [1:0]  have;
   logic [1:0]  acc;

   task automatic model_reset();
      rr         = 0;
      lk         = -1;
      lk_n       = 0;
      last_addr  = '0;
      last_wdata = '0;
      last_size  = '0;
   endtask

   task automatic predict();
      cyc_exp_t e;
      rsp_exp_t r;
      int       g;
      int       w;
      logic     inr;
      g = -1;
      if (lk >= 0) begin
         if (req_valid[lk]) g = lk;
      end else if (req_valid == 2'b11) g = rr;
      else if (req_valid[0]) g = 0;
      else if (req_valid[1]) g = 1;
      e.cyc = cyc;
      e.rdy = 2'b00;
      e.we  = 1'b0;
      e.re  = 1'b0;
      if (g >= 0) begin
         e.rdy[g]   = 1'b1;
         inr        = req_addr[g] < LIMIT;
         e.we       = req_write[g] && inr;
         e.re       = !req_write[g] && inr;
         last_addr  = req_addr[g];
         last_wdata = req_wdata[g];
         last_size  = req_size[g];
         w          = int'(req_addr[g][13:2]);
         r.cyc      = cyc + 1;
         r.err      = !inr;
         r.rdata    = (inr && !req_write[g]) ? ref_mem[w] : 32'h0;
         if (inr && req_write[g])
            for (int b = 0; b < 4; b++)
               if (req_size[g][b]) ref_mem[w][b*8 +: 8] = req_wdata[g][b*8 +: 8];
         rsp_q[g].push_back(r);
         if (lk < 0) begin
            rr = 1 - g;
            if (req_lock[g]) begin
               lk   = g;
               lk_n = 1;
            end
         end else begin
            lk_n++;
            if (!req_lock[g]) lk = -1;
            else if (lk_n == MAXL) begin
               lk = -1;
               rr = 1 - g;
            end
         end
      end else if (lk >= 0) begin
         lk = -1;
      end
      e.addr  = last_addr;
      e.wdata = last_wdata;
      e.size  = last_size;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(negedge clk);
      acc = req_ready & req_valid;
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
         if (have[p] && acc[p]) have[p] = 1'b0;
         if (!have[p] && stim_q[p].size() > 0) begin
            if (stim_q[p][0].gap > 0) begin
               stim_q[p][0].gap = stim_q[p][0].gap - 1;
            end else begin
               cur[p]  = stim_q[p].pop_front();
               have[p] = 1'b1;
            end
         end
         req_valid[p] = have[p];
         req_addr[p]  = cur[p].addr;
         req_wdata[p] = cur[p].wdata;
         req_size[p]  = cur[p].size;
         req_write[p] = cur[p].write;
         req_lock[p]  = cur[p].lock;
      end
      predict();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((stim_q[0].size() + stim_q[1].size() > 0 || have != 2'b00 ||
              rsp_q[0].size() + rsp_q[1].size() > 0) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) to_cnt++;
   endtask

   function automatic req_t mk(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic w,
                               input logic l, input int gap);
      req_t r;
      r.addr  = a;
      r.wdata = d;
      r.size  = s;
      r.write = w;
      r.lock  = l;
      r.gap   = gap;
      return r;
   endfunction

   function automatic req_t rnd_req();
      req_t r;
      logic [11:0] wi;
      if ($urandom_range(0, 9) == 0) begin
         case ($urandom_range(0, 4))
            0:       r.addr = 32'h0000_3FFC;
            1:       r.addr = 32'h0000_3FFF;
            2:       r.addr = 32'h0000_4000;
            3:       r.addr = 32'h0000_4003;
            default: r.addr = 32'hFFFF_FFFC;
         endcase
      end else begin
         wi     = 12'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1) wi = wi + 12'd4032;
         r.addr = {18'd0, wi, 2'b00};
      end
      r.wdata = $urandom;
      r.size  = 4'($urandom_range(0, 15));
      r.write = 1'($urandom_range(0, 1));
      r.lock  = ($urandom_range(0, 3) == 0);
      r.gap   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      return r;
   endfunction

   initial begin : main
      rst_n     = 1'b1;
      req_valid = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_size  = '0;
      req_write = '0;
      req_lock  = '0;
      have      = '0;
      acc       = '0;
      for (int p = 0; p < 2; p++) cur[p] = mk(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 0);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      model_reset();
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Contention: both ports busy for six grants.
      for (int k = 0; k < 3; k++) begin
         stim_q[0].push_back(mk(32'(4 * k), 32'h0, 4'hF, 1'b0, 1'b0, 0));
         stim_q[1].push_back(mk(32'(4 * k + 12), 32'h0, 4'hF, 1'b0, 1'b0, 0));
      end
      drain(40);

      // Single read of the preloaded word.
      stim_q[0].push_back(mk(32'h10, 32'h0, 4'hF, 1'b0, 1'b0, 0));
      drain(20);

      // Lock: port 1 holds 20 locked requests, port 0 waits.
      for (int k = 0; k < 20; k++)
         stim_q[1].push_back(mk(32'(32'h800 + 4 * k), $urandom, 4'hF,
                                1'(k % 2), 1'b1, 0));
      stim_q[0].push_back(mk(32'h804, 32'h0, 4'hF, 1'b0, 1'b0, 1));
      stim_q[0].push_back(mk(32'h808, 32'h0, 4'hF, 1'b0, 1'b0, 0));
      stim_q[0].push_back(mk(32'h80C, 32'h0, 4'hF, 1'b0, 1'b0, 0));
      drain(80);

      // Out-of-range write must not alias onto word 0.
      stim_q[1].push_back(mk(32'h4000, 32'hA5A5A5A5, 4'hF, 1'b1, 1'b0, 0));
      stim_q[0].push_back(mk(32'h0, 32'h0, 4'hF, 1'b0, 1'b0, 1));
      drain(20);

      // Byte-strobe write then read back.
      stim_q[0].push_back(mk(32'h20, 32'h0000AB00, 4'b0010, 1'b1, 1'b0, 0));
      stim_q[0].push_back(mk(32'h20, 32'h0, 4'hF, 1'b0, 1'b0, 0));
      drain(20);

      // Randomized traffic on both ports.
      for (int k = 0; k < 150; k++) begin
         stim_q[0].push_back(rnd_req());
         stim_q[1].push_back(rnd_req());
      end
      drain(3000);

      // Reset during the response cycle of a read.
      stim_q[0].push_back(mk(32'h10, 32'h0, 4'hF, 1'b0, 1'b0, 0));
      step();
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      req_valid = '0;
      have      = '0;
      exp_q.delete();
      rsp_q[0].delete();
      rsp_q[1].delete();
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      stim_q[0].push_back(mk(32'h14, 32'h0, 4'hF, 1'b0, 1'b0, 0));
      stim_q[1].push_back(mk(32'h18, 32'h0, 4'hF, 1'b0, 1'b0, 0));
      drain(20);

      repeat (3) @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
